// File: rtl/logic_unit_pkg.sv
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Shared types and constants for the logic_unit block:
//                bitwise operation encoding and delivery-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    // Bitwise operation select; all eight codes are defined
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_NOTB = 3'd7
    } op_e;

    // Width of the delivered-result counter
    localparam int CNT_W = 16;

endpackage : logic_unit_pkg

`default_nettype wire

// File: rtl/logic_unit_alu.sv
// ============================================================================
//  Module      : logic_unit_alu
//  Description : Purely combinational WIDTH-bit bitwise operator. An unknown
//                op code propagates X to the result rather than being masked.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_alu
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic [WIDTH-1:0] res_out
);

    // Select the bitwise function; X on the select is propagated, not hidden
    always_comb begin
        res_out = {WIDTH{1'bx}};
        case (op_e'(op_in))
            OP_AND:  res_out =   a_in & b_in;
            OP_OR:   res_out =   a_in | b_in;
            OP_XOR:  res_out =   a_in ^ b_in;
            OP_NAND: res_out = ~(a_in & b_in);
            OP_NOR:  res_out = ~(a_in | b_in);
            OP_XNOR: res_out = ~(a_in ^ b_in);
            OP_NOTA: res_out =  ~a_in;
            OP_NOTB: res_out =  ~b_in;
            default: res_out = {WIDTH{1'bx}};
        endcase
    end

endmodule : logic_unit_alu

`default_nettype wire

// File: rtl/logic_unit.sv
// ============================================================================
//  Module      : logic_unit
//  Description : Bitwise logic unit with valid/ready handshake. One output
//                register plus one skid register; in_ready is registered so
//                there is no combinational path from out_ready. A 16-bit
//                counter tracks delivered results.
//                Optional macro LOGIC_UNIT_REDUCE_EN adds red_out =
//                {^res, |res, &res}, registered alongside res_out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             zero_out,
`ifdef LOGIC_UNIT_REDUCE_EN
    output logic [2:0]       red_out,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] txn_cnt_out
);

`ifdef LOGIC_UNIT_REDUCE_EN
    localparam int RED_W = 3;
`else
    localparam int RED_W = 0;
`endif

    // Buffered payload: {[red,] zero, res}
    localparam int PW = WIDTH + 1 + RED_W;

    logic [WIDTH-1:0] alu_res;
    logic [PW-1:0]    new_data;
    logic             accept;
    logic             drain;

    logic             out_valid_q,  out_valid_d;
    logic [PW-1:0]    out_data_q,   out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [PW-1:0]    skid_data_q,  skid_data_d;
    logic             in_ready_q,   in_ready_d;
    logic [CNT_W-1:0] txn_cnt_q,    txn_cnt_d;

    logic_unit_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_in    (a_in),
        .b_in    (b_in),
        .op_in   (op_in),
        .res_out (alu_res)
    );

    // Pack the ALU result with its flags ahead of the buffer
`ifdef LOGIC_UNIT_REDUCE_EN
    assign new_data = {^alu_res, |alu_res, &alu_res, (alu_res == '0), alu_res};
`else
    assign new_data = {(alu_res == '0), alu_res};
`endif

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    // Output/skid buffer next-state: skid always feeds the output first to keep order
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        txn_cnt_d    = drain ? (txn_cnt_q + CNT_W'(1)) : txn_cnt_q;

        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = new_data;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = new_data;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_data;
        end

        // Ready only when the skid slot will be free next cycle
        in_ready_d = !skid_valid_d;
    end

    // State registers, asynchronously cleared so reset discards buffered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
            txn_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            txn_cnt_q    <= txn_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign res_out     = out_data_q[WIDTH-1:0];
    assign zero_out    = out_data_q[WIDTH];
    assign txn_cnt_out = txn_cnt_q;
`ifdef LOGIC_UNIT_REDUCE_EN
    assign red_out     = out_data_q[PW-1 -: 3];
`endif

endmodule : logic_unit

`default_nettype wire

// File: tb/tb_logic_unit.sv
// ============================================================================
//  Module      : tb_logic_unit
//  Description : Directed self-checking bench for logic_unit (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [2:0]  op_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  res_out;
    logic        zero_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] txn_cnt_out;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic [2:0]  red_out;
`endif

    int checks = 0;
    int errors = 0;

    logic_unit #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_in        (a_in),
        .b_in        (b_in),
        .op_in       (op_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .res_out     (res_out),
        .zero_out    (zero_out),
`ifdef LOGIC_UNIT_REDUCE_EN
        .red_out     (red_out),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .txn_cnt_out (txn_cnt_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a_in      = 8'hA5;
        b_in      = 8'h0F;
        op_in     = 3'd0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (txn_cnt_out !== 16'h0000) begin errors++; $display("FAIL reset_txn_cnt: got %h want 0000", txn_cnt_out); end
        checks++; if (res_out !== 8'h00 || zero_out !== 1'b0) begin errors++; $display("FAIL reset_res: got %h/%b want 00/0", res_out, zero_out); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_ops();
        logic [7:0] exp_res [8];
        exp_res = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hF0};
        a_in      = 8'hA5;
        b_in      = 8'h0F;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op_in    = 3'(i);
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || res_out !== exp_res[i]) begin
                errors++;
                $display("FAIL op_%0d: got valid=%b res=%h want valid=1 res=%h", i, out_valid, res_out, exp_res[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ops_drained: got %b want 0", out_valid); end
        checks++; if (txn_cnt_out !== 16'd8) begin errors++; $display("FAIL ops_txn_cnt: got %0d want 8", txn_cnt_out); end
    endtask

    task automatic test_backpressure();
        a_in      = 8'hA5;
        b_in      = 8'h0F;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_in     = 3'd0;
        step();
        checks++; if (out_valid !== 1'b1 || res_out !== 8'h05 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got v=%b res=%h rdy=%b want 1/05/1", out_valid, res_out, in_ready); end
        op_in = 3'd1;
        step();
        checks++; if (in_ready !== 1'b0 || res_out !== 8'h05) begin errors++; $display("FAIL bp_second: got rdy=%b res=%h want 0/05", in_ready, res_out); end
        op_in = 3'd2;
        step();
        checks++; if (in_ready !== 1'b0 || res_out !== 8'h05 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got rdy=%b res=%h v=%b want 0/05/1", in_ready, res_out, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (res_out !== 8'hAF || in_ready !== 1'b1 || txn_cnt_out !== 16'd9) begin errors++; $display("FAIL bp_skid_move: got res=%h rdy=%b cnt=%0d want AF/1/9", res_out, in_ready, txn_cnt_out); end
        step();
        checks++; if (res_out !== 8'hAA || out_valid !== 1'b1 || txn_cnt_out !== 16'd10) begin errors++; $display("FAIL bp_third: got res=%h v=%b cnt=%0d want AA/1/10", res_out, out_valid, txn_cnt_out); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || txn_cnt_out !== 16'd11) begin errors++; $display("FAIL bp_done: got v=%b cnt=%0d want 0/11", out_valid, txn_cnt_out); end
    endtask

    task automatic test_zero();
        a_in      = 8'hFF;
        b_in      = 8'hFF;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_in     = 3'd2;
        step();
        checks++; if (res_out !== 8'h00 || zero_out !== 1'b1) begin errors++; $display("FAIL zero_xor: got res=%h z=%b want 00/1", res_out, zero_out); end
`ifdef LOGIC_UNIT_REDUCE_EN
        checks++; if (red_out !== 3'b000) begin errors++; $display("FAIL red_xor: got %b want 000", red_out); end
`endif
        op_in = 3'd0;
        step();
        checks++; if (res_out !== 8'hFF || zero_out !== 1'b0) begin errors++; $display("FAIL zero_and: got res=%h z=%b want FF/0", res_out, zero_out); end
`ifdef LOGIC_UNIT_REDUCE_EN
        checks++; if (red_out !== 3'b011) begin errors++; $display("FAIL red_and: got %b want 011", red_out); end
`endif
        in_valid = 1'b0;
        step();
        checks++; if (txn_cnt_out !== 16'd13) begin errors++; $display("FAIL zero_txn_cnt: got %0d want 13", txn_cnt_out); end
    endtask

    task automatic test_mid_reset();
        a_in      = 8'hA5;
        b_in      = 8'h0F;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_in     = 3'd1;
        step();
        op_in = 3'd2;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got v=%b rdy=%b want 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || txn_cnt_out !== 16'd0) begin errors++; $display("FAIL mid_async_clear: got v=%b rdy=%b cnt=%0d want 0/0/0", out_valid, in_ready, txn_cnt_out); end
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || txn_cnt_out !== 16'd0) begin
                errors++;
                $display("FAIL mid_no_deliver_%0d: got v=%b cnt=%0d want 0/0", i, out_valid, txn_cnt_out);
            end
        end
    endtask

    task automatic test_wrap();
        a_in      = 8'h3C;
        b_in      = 8'hC3;
        op_in     = 3'd1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        in_valid = 1'b0;
        step();
        checks++; if (txn_cnt_out !== 16'hFFFF || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_preload: got cnt=%h v=%b want FFFF/0", txn_cnt_out, out_valid); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (res_out !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_last_res: got res=%h v=%b want FF/1", res_out, out_valid); end
        step();
        checks++; if (txn_cnt_out !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", txn_cnt_out); end
    endtask

    initial begin
        rst_n     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        op_in     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_ops();
        test_backpressure();
        test_zero();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_logic_unit

`default_nettype wire

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (1..64).
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port a_in  input  WIDTH  operand A.
REQ-005 Port b_in  input  WIDTH  operand B.
REQ-006 Port op_in  input  3  operation select, encoding per REQ-013.
REQ-007 Port in_valid  input  1  operands and op valid this cycle.
REQ-008 Port in_ready  output  1  unit accepts operands this cycle.
REQ-009 Port res_out  output  WIDTH  bitwise result.
REQ-010 Port zero_out  output  1  res_out equals all-zero.
REQ-011 Port out_valid  output  1  res_out, zero_out and red_out are valid.
REQ-012 Port out_ready  input  1  downstream accepts the result.
REQ-012a Port txn_cnt_out  output  16  count of results delivered, wraps at 16'hFFFF -> 0.

Function
REQ-013 The unit SHALL use this op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 NOT B, applied bitwise across WIDTH.
REQ-014 The unit SHALL accept a transaction when in_valid && in_ready at a clock edge.
REQ-015 The unit SHALL present an accepted result on res_out with out_valid high exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-016 The unit SHALL hold a result until out_valid && out_ready at a clock edge, keeping res_out, zero_out and red_out stable while out_valid && !out_ready.
REQ-017 Buffering: one output register plus one skid register. An accept with the output register full and not draining SHALL write the skid register.
REQ-018 in_ready SHALL be a registered signal equal to !skid_valid, with no combinational path from out_ready.
REQ-019 On drain with the skid register full, the skid register SHALL move to the output register on the same edge, and skid_valid SHALL clear unless a simultaneous accept occurs.
REQ-020 Accept and drain on the same edge SHALL preserve order, with no loss or duplication. Sustained throughput SHALL be 1 result per cycle while out_ready stays high.
REQ-021 txn_cnt_out SHALL increment by 1 on each out_valid && out_ready edge.
REQ-022 Illegal ops do not exist: all 8 codes are defined. An unknown or X op SHALL NOT be masked.

Reset
REQ-023 While rst_n is low, the unit SHALL asynchronously clear: out_valid=0, skid_valid=0, in_ready=0, res_out=0, zero_out=0, red_out=0, txn_cnt_out=0.
REQ-024 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.
REQ-025 Reset asserted mid-transfer SHALL discard both buffered results, with no drain pulse.

Configuration
REQ-026 Macro LOGIC_UNIT_REDUCE_EN defined: add port red_out (output, 3 bits) = {^res, |res, &res}, registered alongside res_out.
REQ-027 Macro LOGIC_UNIT_REDUCE_EN undefined: red_out SHALL be absent and no reduction logic SHALL be present.

Structure
REQ-028 Package logic_unit_pkg SHALL hold the op_e enum (8 codes) and the constant CNT_W=16.
REQ-029 The bitwise operation SHALL live in sub-module logic_unit_alu (purely combinational, WIDTH-parameterised), instanced once ahead of the buffer.

Verification
REQ-030 Reset: hold rst_n low 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, txn_cnt_out=0; in_ready=1 one edge after release.
REQ-031 Ops, WIDTH=8: a=8'hA5, b=8'h0F, out_ready=1, op 0..7 back-to-back -> 05,AF,AA,FA,50,55,5A,F0, one per cycle, txn_cnt_out=8.
REQ-032 Backpressure: out_ready=0, send 3 ops -> 2 accepted, in_ready=0 after the second; release out_ready -> in-order delivery, then third accepted.
REQ-033 Zero flag: a=8'hFF, b=8'hFF, op XOR -> res_out=00, zero_out=1; with macro, red_out=3'b000; op AND -> red_out=3'b011.
REQ-034 Wrap: preload 16'hFFFF deliveries (or force) then 1 more -> txn_cnt_out=0.
REQ-035 Mid-op reset: both buffers full, pulse rst_n low -> out_valid=0 immediately, no result delivered after release.
